uart_keycode_sender: RTL and testbench



---
 rtl/uart_defs.sv | 45 ++++
 rtl/keycode_fifo.sv | 62 ++++++
 rtl/uart_keycode_sender.sv | 96 +++++++++
 tb/tb_uart_keycode_sender.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
`default_nettype none
// ============================================================================
// Module   : uart_defs
// Purpose  : Shared constants, FSM encoding and byte-map helpers for the
//            keycode-to-UART sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package uart_defs;

    localparam logic [7:0] c_ASCII_CR      = 8'h0D;
    localparam logic [7:0] c_ASCII_LF      = 8'h0A;
    localparam logic [7:0] c_HEX_DIGIT_OFS = 8'h30;
    localparam logic [7:0] c_HEX_ALPHA_OFS = 8'h37;

    localparam int unsigned c_MSG_LEN  = 6;
    localparam logic [2:0]  c_LAST_IDX = 3'(c_MSG_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib <= 4'd9) ? (c_HEX_DIGIT_OFS + {4'h0, nib})
                             : (c_HEX_ALPHA_OFS + {4'h0, nib});
    endfunction

    // Message layout: four hex digits MSB nibble first, then CR, LF.
    function automatic logic [7:0] msg_byte(input logic [15:0] code,
                                            input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = hex_ascii(code[15:12]);
            3'd1:    b = hex_ascii(code[11:8]);
            3'd2:    b = hex_ascii(code[7:4]);
            3'd3:    b = hex_ascii(code[3:0]);
            3'd4:    b = c_ASCII_CR;
            default: b = c_ASCII_LF;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keycode_fifo.sv
`default_nettype none
// ============================================================================
// Module   : keycode_fifo
// Purpose  : Synchronous first-word-fall-through FIFO for keyboard codes.
// Revision : 1.0 - initial release
// ============================================================================
module keycode_fifo #(
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    logic [WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign full   = (r_count == (FIFO_AW+1)'(FIFO_DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_keycode_sender.sv
`default_nettype none
// ============================================================================
// Module   : uart_keycode_sender
// Purpose  : Buffers 16-bit keycodes and streams each as "HHHH\r\n" to uart_tx.
// Revision : 1.0 - initial release
// ============================================================================
module uart_keycode_sender
    import uart_defs::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] key_code,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic        tx_ready,
    output logic [7:0]  tbus,
    output logic        tstart,
    output logic        busy
);

    state_t      r_state;
    logic [2:0]  r_idx;
    logic [15:0] r_cur;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [15:0] w_head;

    assign key_ready = !w_full && !rst;
    assign w_push    = key_valid && key_ready;
    // tx_ready may feed the pop path but never tstart: uart_tx derives ready from tstart.
    assign w_pop     = (r_state == ST_IDLE) && !w_empty && tx_ready;
    assign busy      = !w_empty || (r_state != ST_IDLE);

    keycode_fifo #(
        .WIDTH      (16),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (key_code),
        .full  (w_full),
        .pop   (w_pop),
        .dout  (w_head),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cur   <= '0;
            tbus    <= 8'h00;
            tstart  <= 1'b0;
        end else begin
            tstart <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_cur   <= w_head;
                        r_idx   <= 3'd0;
                        tbus    <= msg_byte(w_head, 3'd0);
                        tstart  <= 1'b1;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_ready) begin
                        if (r_idx < c_LAST_IDX) begin
                            r_idx   <= r_idx + 3'd1;
                            tbus    <= msg_byte(r_cur, r_idx + 3'd1);
                            tstart  <= 1'b1;
                            r_state <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_keycode_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_keycode_sender
// Purpose  : Self-checking bench pairing the sequencer with a uart_tx model
//            (CD_MAX = 3, 44-cycle frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_keycode_sender;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] key_code;
    logic        key_valid;
    logic        key_ready;
    logic        tx_ready;
    logic [7:0]  tbus;
    logic        tstart;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_keycode_sender #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .tx_ready  (tx_ready),
        .tbus      (tbus),
        .tstart    (tstart),
        .busy      (busy)
    );

    // uart_tx model: no reset, 44-cycle frame, ready high when idle or in the last cycle.
    logic       tx_run = 1'b0;
    int         tx_cnt = 0;
    logic [7:0] rx_q[$];
    int         overlap_err = 0;
    int         width_err = 0;
    int         pulses = 0;
    logic       prev_tstart = 1'b0;

    assign tx_ready = (!tx_run || tx_cnt == 43) && !tstart;

    always @(posedge clk) begin
        if (tx_run) begin
            if (tstart) overlap_err <= overlap_err + 1;
            if (tx_cnt == 43) tx_run <= 1'b0;
            else tx_cnt <= tx_cnt + 1;
        end else if (tstart) begin
            tx_run <= 1'b1;
            tx_cnt <= 0;
            rx_q.push_back(tbus);
        end
        if (tstart && prev_tstart) width_err <= width_err + 1;
        if (tstart && !prev_tstart) pulses <= pulses + 1;
        prev_tstart <= tstart;
    end

    typedef struct packed {
        logic [15:0] code;
        logic [47:0] bytes;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input logic [15:0] code, input int i);
        logic [3:0] n;
        if (i == 4) return 8'h0D;
        if (i == 5) return 8'h0A;
        n = code[15 - 4*i -: 4];
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    task automatic push_one(input logic [15:0] code);
        int cyc = 0;
        key_code  = code;
        key_valid = 1'b1;
        while (!key_ready && cyc < 3000) begin
            step();
            cyc++;
        end
        step();
        key_valid = 1'b0;
        if (cyc >= 3000) chk("push_timeout", 32'(cyc), 0);
    endtask

    task automatic wait_done();
        int cyc = 0;
        step();
        while ((busy || tx_run) && cyc < 3000) begin
            step();
            cyc++;
        end
        if (cyc >= 3000) chk("done_timeout", 32'(cyc), 0);
    endtask

    task automatic check_msg(input string name, input int base, input logic [47:0] exp);
        logic [7:0] act;
        for (int i = 0; i < 6; i++) begin
            act = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
            chk(name, {24'h0, act}, {24'h0, exp[47 - 8*i -: 8]});
        end
    endtask

    initial begin
        int base;
        int p0;
        int acc;
        int cyc;
        int bad;
        logic [47:0] e;

        vecs[0] = '{code: 16'hF01C, bytes: 48'h4630_3143_0D0A};
        vecs[1] = '{code: 16'h09AF, bytes: 48'h3039_4146_0D0A};
        vecs[2] = '{code: 16'hFFFF, bytes: 48'h4646_4646_0D0A};
        vecs[3] = '{code: 16'h7A3E, bytes: 48'h3741_3345_0D0A};
        vecs[4] = '{code: 16'hA5B6, bytes: 48'h4135_4236_0D0A};

        rst = 1'b1;
        key_code = 16'h0000;
        key_valid = 1'b0;
        repeat (3) step();
        chk("rst_tstart", {31'h0, tstart}, 0);
        chk("rst_tbus", {24'h0, tbus}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_key_ready", {31'h0, key_ready}, 0);
        rst = 1'b0;
        step();
        chk("post_rst_key_ready", {31'h0, key_ready}, 1);

        // Start latency and pulse count for a single code.
        base = rx_q.size();
        p0 = pulses;
        key_code = 16'hF01C;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        chk("lat_tstart_k", {31'h0, tstart}, 0);
        step();
        chk("lat_tstart_k1", {31'h0, tstart}, 1);
        chk("lat_tbus_b0", {24'h0, tbus}, 32'h46);
        step();
        chk("lat_tstart_k2", {31'h0, tstart}, 0);
        chk("lat_tbus_hold", {24'h0, tbus}, 32'h46);
        wait_done();
        chk("single_pulses", 32'(pulses - p0), 6);
        check_msg("single_bytes", base, vecs[0].bytes);

        for (int v = 1; v < 5; v++) begin
            base = rx_q.size();
            push_one(vecs[v].code);
            wait_done();
            chk("vec_len", 32'(rx_q.size() - base), 6);
            check_msg("vec_bytes", base, vecs[v].bytes);
        end

        // Backpressure: hold valid with codes 1..6.
        base = rx_q.size();
        acc = 0;
        cyc = 0;
        key_code = 16'h0001;
        key_valid = 1'b1;
        while (key_ready && cyc < 20) begin
            step();
            acc++;
            cyc++;
            key_code = 16'(acc + 1);
        end
        chk("bp_accepted", 32'(acc), 5);
        chk("bp_key_ready_low", {31'h0, key_ready}, 0);
        cyc = 0;
        while (!key_ready && cyc < 3000) begin
            step();
            cyc++;
        end
        chk("bp_key_ready_back", {31'h0, key_ready}, 1);
        step();
        key_valid = 1'b0;
        wait_done();
        chk("bp_len", 32'(rx_q.size() - base), 36);
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < 6; i++) e[47 - 8*i -: 8] = exp_byte(16'(c + 1), i);
            check_msg("bp_bytes", base + 6*c, e);
        end

        // Push on the exact IDLE->START pop edge.
        base = rx_q.size();
        key_code = 16'h1111;
        key_valid = 1'b1;
        step();
        key_code = 16'h2222;
        step();
        key_valid = 1'b0;
        chk("pp_tstart", {31'h0, tstart}, 1);
        chk("pp_occupancy", 32'(dut.u_fifo.r_count), 1);
        wait_done();
        check_msg("pp_first", base, 48'h3131_3131_0D0A);
        check_msg("pp_second", base + 6, 48'h3232_3232_0D0A);

        // Reset during byte 2 of a message.
        base = rx_q.size();
        push_one(16'h7A3E);
        cyc = 0;
        while (rx_q.size() < base + 3 && cyc < 3000) begin
            step();
            cyc++;
        end
        repeat (5) step();
        chk("mid_tx_running", {31'h0, tx_run}, 1);
        rst = 1'b1;
        repeat (2) step();
        chk("mid_rst_tstart", {31'h0, tstart}, 0);
        rst = 1'b0;
        key_code = 16'h1234;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        base = rx_q.size();
        bad = 0;
        cyc = 0;
        while (tx_run && cyc < 3000) begin
            if (tstart) bad++;
            step();
            cyc++;
        end
        chk("mid_holdoff", 32'(bad), 0);
        wait_done();
        chk("mid_len", 32'(rx_q.size() - base), 6);
        check_msg("mid_bytes", base, 48'h3132_3334_0D0A);

        chk("no_overlap", 32'(overlap_err), 0);
        chk("pulse_width", 32'(width_err), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
